// File: rtl/parking_lot_fsm_pkg.sv
// Shared types for the parking-lot gate decoder: FSM states and the 2-bit
// sensor codes {a, b}.
package parking_lot_fsm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      E1,
      E2,
      E3,
      X1,
      X2,
      X3,
      WAIT
   } state_t;

   localparam logic [1:0] S_CLEAR = 2'b00;
   localparam logic [1:0] S_OUTER = 2'b10;
   localparam logic [1:0] S_BOTH  = 2'b11;
   localparam logic [1:0] S_INNER = 2'b01;

endpackage

// File: rtl/parking_lot_fsm_sensor_sync.sv
// N-stage, 2-bit flop synchroniser with asynchronous active-low clear.
// N = 0 turns it into a plain wire for inputs that are already synchronous.
module sensor_sync #(
   parameter int N = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] d,
   output logic [1:0] q
);

   generate
      if (N == 0) begin : g_pass
         assign q = d;
      end else begin : g_chain
         for (genvar gi = 0; gi < N; gi++) begin : g_stage
            logic [1:0] q_reg;
            logic [1:0] d_in;

            if (gi == 0) begin : g_first
               assign d_in = d;
            end else begin : g_next
               assign d_in = g_stage[gi-1].q_reg;
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  q_reg <= 2'b00;
               end else begin
                  q_reg <= d_in;
               end
            end
         end

         assign q = g_stage[N-1].q_reg;
      end
   endgenerate

endmodule

// File: rtl/parking_lot_fsm.sv
// Gate-lane sensor decoder: follows the break/clear order of beams a and b and
// pulses enter or exit once per completed car passage.
// Optional err output (pulses on entry to WAIT) when PARKING_LOT_FSM_ERR_EN is defined.
module parking_lot_fsm
   import parking_lot_fsm_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic b,
   output logic enter,
`ifdef PARKING_LOT_FSM_ERR_EN
   output logic err,
`endif
   output logic exit
);

   state_t     state_reg;
   state_t     state_next;
   logic       enter_reg;
   logic       enter_next;
   logic       exit_reg;
   logic       exit_next;
   logic [1:0] s;

   sensor_sync #(
      .N(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(reset),
      .d    ({a, b}),
      .q    (s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         enter_reg <= 1'b0;
         exit_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         enter_reg <= enter_next;
         exit_reg  <= exit_next;
      end
   end

   // Any sensor code not on the legal path parks the FSM in WAIT until the lane clears.
   always_comb begin
      state_next = state_reg;
      enter_next = 1'b0;
      exit_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            case (s)
               S_OUTER: state_next = E1;
               S_INNER: state_next = X1;
               S_BOTH:  state_next = WAIT;
               default: state_next = IDLE;
            endcase
         end
         E1: begin
            case (s)
               S_BOTH:  state_next = E2;
               S_CLEAR: state_next = IDLE;
               S_INNER: state_next = WAIT;
               default: state_next = E1;
            endcase
         end
         E2: begin
            case (s)
               S_INNER: state_next = E3;
               S_OUTER: state_next = E1;
               S_CLEAR: state_next = WAIT;
               default: state_next = E2;
            endcase
         end
         E3: begin
            case (s)
               S_CLEAR: begin
                  state_next = IDLE;
                  enter_next = 1'b1;
               end
               S_BOTH:  state_next = E2;
               S_OUTER: state_next = WAIT;
               default: state_next = E3;
            endcase
         end
         X1: begin
            case (s)
               S_BOTH:  state_next = X2;
               S_CLEAR: state_next = IDLE;
               S_OUTER: state_next = WAIT;
               default: state_next = X1;
            endcase
         end
         X2: begin
            case (s)
               S_OUTER: state_next = X3;
               S_INNER: state_next = X1;
               S_CLEAR: state_next = WAIT;
               default: state_next = X2;
            endcase
         end
         X3: begin
            case (s)
               S_CLEAR: begin
                  state_next = IDLE;
                  exit_next  = 1'b1;
               end
               S_BOTH:  state_next = X2;
               S_INNER: state_next = WAIT;
               default: state_next = X3;
            endcase
         end
         WAIT: begin
            if (s == S_CLEAR) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign enter = enter_reg;
   assign exit  = exit_reg;

`ifdef PARKING_LOT_FSM_ERR_EN
   logic err_reg;
   logic err_next;

   assign err_next = (state_next == WAIT) && (state_reg != WAIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_reg <= 1'b0;
      end else begin
         err_reg <= err_next;
      end
   end

   assign err = err_reg;
`endif

endmodule

// File: tb/tb_parking_lot_fsm.sv
// Scoreboard bench for parking_lot_fsm: one instance with SYNC_STAGES=0 and one
// with SYNC_STAGES=2 share the same stimulus; expected pulses are queued per DUT.
module tb_parking_lot_fsm;
   import parking_lot_fsm_pkg::*;

   typedef struct {
      int kind;
      int cyc;
   } exp_t;

   localparam int K_ENTER = 1;
   localparam int K_EXIT  = 2;
`ifdef PARKING_LOT_FSM_ERR_EN
   localparam int K_ERR   = 3;
`else
   localparam int K_ERR   = 0;
`endif

   logic clk;
   logic reset;
   logic a;
   logic b;
   logic enter0, exit0, enter2, exit2;
`ifdef PARKING_LOT_FSM_ERR_EN
   logic err0, err2;
`else
   wire  err0 = 1'b0;
   wire  err2 = 1'b0;
`endif

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t q0[$];
   exp_t q2[$];
   exp_t e0;
   exp_t e2;
   int   kind0, kind2;

   parking_lot_fsm #(.SYNC_STAGES(0)) dut0 (
      .clk  (clk),
      .reset(reset),
      .a    (a),
      .b    (b),
      .enter(enter0),
`ifdef PARKING_LOT_FSM_ERR_EN
      .err  (err0),
`endif
      .exit (exit0)
   );

   parking_lot_fsm #(.SYNC_STAGES(2)) dut2 (
      .clk  (clk),
      .reset(reset),
      .a    (a),
      .b    (b),
      .enter(enter2),
`ifdef PARKING_LOT_FSM_ERR_EN
      .err  (err2),
`endif
      .exit (exit2)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc++;

   // Monitor for the unsynchronised instance.
   always @(negedge clk) begin
      if (reset) begin
         kind0 = enter0 ? K_ENTER : exit0 ? K_EXIT : err0 ? 3 : 0;
         if (kind0 != 0) begin
            checks++;
            if (int'(enter0) + int'(exit0) + int'(err0) > 1) begin
               errors++;
               $display("FAIL dut0 overlap: enter=%0d exit=%0d err=%0d, required one at a time",
                        enter0, exit0, err0);
            end else if (q0.size() == 0) begin
               errors++;
               $display("FAIL dut0 unexpected pulse: kind %0d at cycle %0d, required none", kind0, cyc);
            end else begin
               e0 = q0.pop_front();
               if (e0.kind != kind0 || e0.cyc != cyc) begin
                  errors++;
                  $display("FAIL dut0 pulse: kind %0d at cycle %0d, required kind %0d at cycle %0d",
                           kind0, cyc, e0.kind, e0.cyc);
               end else begin
                  $display("dut0 pulse kind %0d at cycle %0d ok", kind0, cyc);
               end
            end
         end
      end
   end

   // Monitor for the two-stage synchroniser instance.
   always @(negedge clk) begin
      if (reset) begin
         kind2 = enter2 ? K_ENTER : exit2 ? K_EXIT : err2 ? 3 : 0;
         if (kind2 != 0) begin
            checks++;
            if (int'(enter2) + int'(exit2) + int'(err2) > 1) begin
               errors++;
               $display("FAIL dut2 overlap: enter=%0d exit=%0d err=%0d, required one at a time",
                        enter2, exit2, err2);
            end else if (q2.size() == 0) begin
               errors++;
               $display("FAIL dut2 unexpected pulse: kind %0d at cycle %0d, required none", kind2, cyc);
            end else begin
               e2 = q2.pop_front();
               if (e2.kind != kind2 || e2.cyc != cyc) begin
                  errors++;
                  $display("FAIL dut2 pulse: kind %0d at cycle %0d, required kind %0d at cycle %0d",
                           kind2, cyc, e2.kind, e2.cyc);
               end else begin
                  $display("dut2 pulse kind %0d at cycle %0d ok", kind2, cyc);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end else begin
         $display("%s = %0d ok", name, act);
      end
   endtask

   // Drive one sensor code for two cycles; a non-zero kind queues the pulse
   // that this change completes (latency SYNC_STAGES+1 edges).
   task automatic step(input logic [1:0] code, input int kind);
      @(negedge clk);
      {a, b} = code;
      if (kind != 0) begin
         q0.push_back('{kind, cyc + 1});
         q2.push_back('{kind, cyc + 3});
      end
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int w;
      w = 0;
      while ((q0.size() != 0 || q2.size() != 0) && w < 12) begin
         @(negedge clk);
         w++;
      end
      repeat (4) @(negedge clk);
      checks++;
      if (q0.size() != 0 || q2.size() != 0) begin
         errors++;
         $display("FAIL %s drain: pending dut0=%0d dut2=%0d, required 0 and 0",
                  name, q0.size(), q2.size());
         q0.delete();
         q2.delete();
      end else begin
         $display("%s: all expected pulses seen", name);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      a     = 1'b0;
      b     = 1'b0;
      #5;
      chk("reset enter0", int'(enter0), 0);
      chk("reset exit0", int'(exit0), 0);
      chk("reset enter2", int'(enter2), 0);
      chk("reset exit2", int'(exit2), 0);
      chk("reset state0", int'(dut0.state_reg), int'(IDLE));
      #25;
      reset = 1'b1;

      // Entry
      step(S_CLEAR, 0);
      step(S_OUTER, 0);
      step(S_BOTH, 0);
      step(S_INNER, 0);
      step(S_CLEAR, K_ENTER);
      drain("entry");
      chk("entry state0", int'(dut0.state_reg), int'(IDLE));

      // Exit
      step(S_INNER, 0);
      step(S_BOTH, 0);
      step(S_OUTER, 0);
      step(S_CLEAR, K_EXIT);
      drain("exit");

      // Back-out, then a full entry
      step(S_OUTER, 0);
      step(S_BOTH, 0);
      step(S_OUTER, 0);
      step(S_CLEAR, 0);
      drain("backout");
      chk("backout state0", int'(dut0.state_reg), int'(IDLE));
      chk("backout state2", int'(dut2.state_reg), int'(IDLE));
      step(S_OUTER, 0);
      step(S_BOTH, 0);
      step(S_INNER, 0);
      step(S_CLEAR, K_ENTER);
      drain("entry after backout");

      // Illegal jump into WAIT
      step(S_BOTH, K_ERR);
      step(S_INNER, 0);
      step(S_CLEAR, 0);
      drain("illegal");
      chk("illegal state0", int'(dut0.state_reg), int'(IDLE));

      // Reset mid-sequence: asserted between edges, must act at once
      step(S_OUTER, 0);
      step(S_BOTH, 0);
      step(S_INNER, 0);
      chk("pre-reset state0", int'(dut0.state_reg), int'(E3));
      #5;
      reset = 1'b0;
      #1;
      chk("mid reset state0", int'(dut0.state_reg), int'(IDLE));
      chk("mid reset state2", int'(dut2.state_reg), int'(IDLE));
      chk("mid reset enter0", int'(enter0), 0);
      {a, b} = S_CLEAR;
      #29;
      reset = 1'b1;
      drain("after reset");
      chk("post reset state0", int'(dut0.state_reg), int'(IDLE));
      chk("post reset state2", int'(dut2.state_reg), int'(IDLE));

      // Back-to-back entry then exit
      step(S_OUTER, 0);
      step(S_BOTH, 0);
      step(S_INNER, 0);
      step(S_CLEAR, K_ENTER);
      step(S_INNER, 0);
      step(S_BOTH, 0);
      step(S_OUTER, 0);
      step(S_CLEAR, K_EXIT);
      step(S_CLEAR, 0);
      drain("back-to-back");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
